// File: rtl/fsm_cnt_pkg.sv
// Shared definitions for the 2-bit up/down counter and its receive-side
// direction decoder: FSM state codes, command codes and the wrap-around
// delta helper.
package fsm_cnt_pkg;

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] X_HOLD = 2'b00;
    localparam logic [1:0] X_UP   = 2'b01;
    localparam logic [1:0] X_DOWN = 2'b10;
    localparam logic [1:0] X_ERR  = 2'b11;

    // Step between two consecutive samples of a mod-4 count:
    // 0 = no motion, 1 = +1, 3 = -1, 2 = ambiguous (a step was missed).
    function automatic logic [1:0] delta_mod4(input logic [1:0] cur,
                                              input logic [1:0] prev);
        return cur - prev;
    endfunction

endpackage

// File: rtl/cnt_sync.sv
// Multi-stage synchronizer for the 2-bit count coming from the counter.
// Free-running; the count is Gray-like in the sense that legal steps change
// the value by one, and illegal jumps are caught downstream as faults.
module cnt_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] stage_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the (possibly asynchronous) input.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) stage_reg[gi] <= 2'b00;
                    else      stage_reg[gi] <= din;
                end
            end else begin : g_rest
                // Later stages give metastability time to resolve.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) stage_reg[gi] <= 2'b00;
                    else      stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/count_direction_decoder.sv
// Receive side of the 2-bit up/down counter: synchronizes the count,
// recovers the per-step direction command, keeps a wide position and
// reports missed steps (jumps of 2) as a sticky fault.
module count_direction_decoder
    import fsm_cnt_pkg::*;
#(
    parameter int POS_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [1:0]       Cuenta_in,
    input  logic             Clr_Err,
    output logic [1:0]       X_out,
    output logic             Step_Up,
    output logic             Step_Dn,
    output logic [POS_W-1:0] Pos,
    output logic             Err,
    output logic [ERR_W-1:0] Err_Cnt
);

    logic [1:0]       cur;
    logic [1:0]       delta;
    logic [1:0]       prev_reg;
    state_t           state_reg;
    logic [1:0]       x_reg;
    logic             up_reg;
    logic             dn_reg;
    logic [POS_W-1:0] pos_reg;
    logic             err_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    cnt_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (Clk),
        .rst (Rst),
        .din (Cuenta_in),
        .dout(cur)
    );

    assign delta = delta_mod4(cur, prev_reg);

    // Decode FSM and datapath; every output is registered here.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg   <= ST_ACQ;
            prev_reg    <= 2'b00;
            x_reg       <= X_HOLD;
            up_reg      <= 1'b0;
            dn_reg      <= 1'b0;
            pos_reg     <= '0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            // Pulses last one cycle and the reference always follows the
            // synchronized count, so motion while idle is discarded.
            up_reg   <= 1'b0;
            dn_reg   <= 1'b0;
            prev_reg <= cur;
            case (state_reg)
                ST_ACQ: begin
                    x_reg <= X_HOLD;
                    if (Clr_Err) err_reg <= 1'b0;
                    if (En) state_reg <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (!En) begin
                        x_reg <= X_HOLD;
                        if (Clr_Err) err_reg <= 1'b0;
                    end else begin
                        case (delta)
                            2'd1: begin
                                x_reg   <= X_UP;
                                up_reg  <= 1'b1;
                                pos_reg <= pos_reg + POS_W'(1);
                                if (Clr_Err) err_reg <= 1'b0;
                            end
                            2'd3: begin
                                x_reg   <= X_DOWN;
                                dn_reg  <= 1'b1;
                                pos_reg <= pos_reg - POS_W'(1);
                                if (Clr_Err) err_reg <= 1'b0;
                            end
                            2'd2: begin
                                // A missed step beats a concurrent clear.
                                x_reg     <= X_ERR;
                                err_reg   <= 1'b1;
                                state_reg <= ST_FAULT;
                                if (err_cnt_reg != '1)
                                    err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                            end
                            default: begin
                                x_reg <= X_HOLD;
                                if (Clr_Err) err_reg <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_FAULT: begin
                    // Position is frozen until software acknowledges.
                    if (Clr_Err) begin
                        err_reg   <= 1'b0;
                        x_reg     <= X_HOLD;
                        state_reg <= ST_ACQ;
                    end else begin
                        x_reg <= X_ERR;
                    end
                end
                default: begin
                    x_reg     <= X_HOLD;
                    state_reg <= ST_ACQ;
                end
            endcase
        end
    end

    assign X_out   = x_reg;
    assign Step_Up = up_reg;
    assign Step_Dn = dn_reg;
    assign Pos     = pos_reg;
    assign Err     = err_reg;
    assign Err_Cnt = err_cnt_reg;

endmodule
